// File: rtl/time_core_bcd_if.sv
// Key-pulse and display-side signals of the BCD time-of-day core.
// TIME_CORE_DEC_EN adds the iDecKey line.
interface time_core_bcd_if;
  logic        iModeKey;
  logic        iSelKey;
  logic        iIncKey;
`ifdef TIME_CORE_DEC_EN
  logic        iDecKey;
`endif
  logic [23:0] oTime;
  logic        oSetMode;
  logic [2:0]  oSetSel;
  logic        oSecTick;
  logic        oDayTick;

`ifdef TIME_CORE_DEC_EN
  modport master (output iModeKey, iSelKey, iIncKey, iDecKey,
                  input  oTime, oSetMode, oSetSel, oSecTick, oDayTick);
  modport slave  (input  iModeKey, iSelKey, iIncKey, iDecKey,
                  output oTime, oSetMode, oSetSel, oSecTick, oDayTick);
`else
  modport master (output iModeKey, iSelKey, iIncKey,
                  input  oTime, oSetMode, oSetSel, oSecTick, oDayTick);
  modport slave  (input  iModeKey, iSelKey, iIncKey,
                  output oTime, oSetMode, oSetSel, oSecTick, oDayTick);
`endif
endinterface

// File: rtl/time_core_bcd.sv
// HH:MM:SS packed-BCD time keeper with a per-digit SET mode for the 6-digit scanner.
// Optional macro TIME_CORE_DEC_EN adds a decrement key for SET mode.
module time_core_bcd #(
  parameter int          CLK_HZ    = 50_000_000,
  parameter logic [23:0] INIT_TIME = 24'h12_00_00
) (
  input logic             CLOCK,
  input logic             RESET,
  time_core_bcd_if.slave  bus
);

  typedef enum logic {RUN, SET} state_t;

  localparam logic [25:0] TERM = 26'(CLK_HZ - 1);

  state_t      state, state_next;
  logic [25:0] presc, presc_next;
  logic [23:0] time_q, time_next;
  logic [2:0]  sel_q, sel_next;
  logic        set_q, set_next;
  logic        sec_q, sec_next;
  logic        day_q, day_next;

  logic mode_key, sel_key, inc_key;
  assign mode_key = bus.iModeKey;
  assign sel_key  = bus.iSelKey;
  assign inc_key  = bus.iIncKey;

  assign bus.oTime    = time_q;
  assign bus.oSetMode = set_q;
  assign bus.oSetSel  = sel_q;
  assign bus.oSecTick = sec_q;
  assign bus.oDayTick = day_q;

  function automatic logic [23:0] next_second(input logic [23:0] t);
    logic [3:0] ht, hu, mt, mu, st, su;
    {ht, hu, mt, mu, st, su} = t;
    if (su != 4'd9) su = su + 4'd1;
    else begin
      su = 4'd0;
      if (st != 4'd5) st = st + 4'd1;
      else begin
        st = 4'd0;
        if (mu != 4'd9) mu = mu + 4'd1;
        else begin
          mu = 4'd0;
          if (mt != 4'd5) mt = mt + 4'd1;
          else begin
            mt = 4'd0;
            if (ht == 4'd2 && hu == 4'd3) begin
              ht = 4'd0;
              hu = 4'd0;
            end else if (hu == 4'd9) begin
              hu = 4'd0;
              ht = ht + 4'd1;
            end else begin
              hu = hu + 4'd1;
            end
          end
        end
      end
    end
    return {ht, hu, mt, mu, st, su};
  endfunction

  function automatic logic [3:0] wrap_step(input logic [3:0] d, input logic [3:0] lim,
                                           input logic up);
    if (up) return (d >= lim) ? 4'd0 : d + 4'd1;
    else    return (d == 4'd0) ? lim : d - 4'd1;
  endfunction

  // Edits one digit with no carry; the hour-tens edit clamps Hu so 2x never exceeds 23.
  function automatic logic [23:0] digit_step(input logic [23:0] t, input logic [2:0] sel,
                                             input logic up);
    logic [3:0] ht, hu, mt, mu, st, su;
    {ht, hu, mt, mu, st, su} = t;
    case (sel)
      3'd0: begin
        ht = wrap_step(ht, 4'd2, up);
        if (ht == 4'd2 && hu > 4'd3) hu = 4'd3;
      end
      3'd1:    hu = wrap_step(hu, (ht == 4'd2) ? 4'd3 : 4'd9, up);
      3'd2:    mt = wrap_step(mt, 4'd5, up);
      3'd3:    mu = wrap_step(mu, 4'd9, up);
      3'd4:    st = wrap_step(st, 4'd5, up);
      3'd5:    su = wrap_step(su, 4'd9, up);
      default: ;
    endcase
    return {ht, hu, mt, mu, st, su};
  endfunction

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (mode_key) state_next = (state == RUN) ? SET : RUN;
  end

  // Mode key outranks everything, so a terminal count on the RUN->SET edge is dropped.
  always_comb begin
    time_next  = time_q;
    presc_next = presc;
    sel_next   = sel_q;
    sec_next   = 1'b0;
    day_next   = 1'b0;
    case (state)
      RUN: begin
        sel_next = 3'd0;
        if (mode_key) begin
          presc_next = 26'd0;
        end else if (presc == TERM) begin
          presc_next = 26'd0;
          time_next  = next_second(time_q);
          sec_next   = 1'b1;
          day_next   = (time_q == 24'h23_59_59);
        end else begin
          presc_next = presc + 26'd1;
        end
      end
      SET: begin
        presc_next = 26'd0;
        if (mode_key)      sel_next  = 3'd0;
        else if (sel_key)  sel_next  = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
        else if (inc_key)  time_next = digit_step(time_q, sel_q, 1'b1);
`ifdef TIME_CORE_DEC_EN
        else if (bus.iDecKey) time_next = digit_step(time_q, sel_q, 1'b0);
`endif
      end
      default: ;
    endcase
    set_next = (state_next == SET);
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      presc  <= 26'd0;
      time_q <= INIT_TIME;
      sel_q  <= 3'd0;
      set_q  <= 1'b0;
      sec_q  <= 1'b0;
      day_q  <= 1'b0;
    end else begin
      presc  <= presc_next;
      time_q <= time_next;
      sel_q  <= sel_next;
      set_q  <= set_next;
      sec_q  <= sec_next;
      day_q  <= day_next;
    end
  end

endmodule

// File: tb/tb_time_core_bcd.sv
// Randomized scoreboard bench for time_core_bcd; the model keeps time as seconds-of-day.
// Build with TIME_CORE_DEC_EN to also exercise the decrement key.
module tb_time_core_bcd;

  localparam int          CLK_HZ    = 10;
  localparam logic [23:0] INIT_TIME = 24'h23_59_58;

  logic CLOCK = 1'b0;
  logic RESET = 1'b0;

  time_core_bcd_if bus();

  time_core_bcd #(.CLK_HZ(CLK_HZ), .INIT_TIME(INIT_TIME)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [23:0] t;
    bit          mode;
    int          sel;
    bit          sec;
    bit          day;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int m_secs;
  bit m_set;
  int m_sel;
  int m_start;

  function automatic logic [23:0] to_bcd(input int s);
    int h, mi, se;
    h  = s / 3600;
    mi = (s / 60) % 60;
    se = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
  endfunction

  function automatic int from_bcd(input logic [23:0] b);
    return (int'(b[23:20]) * 10 + int'(b[19:16])) * 3600 +
           (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 +
           int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int digit(input logic [23:0] b, input int pos);
    logic [23:0] t;
    t = b >> (4 * (5 - pos));
    return int'(t[3:0]);
  endfunction

  task automatic push(input int c, input bit sec, input bit day, input string name);
    exp_t e;
    e.cyc  = c;
    e.t    = to_bcd(m_secs);
    e.mode = m_set;
    e.sel  = m_sel;
    e.sec  = sec;
    e.day  = day;
    e.name = name;
    sb.push_back(e);
  endtask

  // Digit edit on the model, expressed on hour/minute/second values with modular wrap.
  task automatic edit(input bit up);
    int h, mi, se, ht, hu, mt, mu, st, su, lim;
    h  = m_secs / 3600;
    mi = (m_secs / 60) % 60;
    se = m_secs % 60;
    ht = h / 10;  hu = h % 10;
    mt = mi / 10; mu = mi % 10;
    st = se / 10; su = se % 10;
    case (m_sel)
      0: begin
        ht = up ? (ht + 1) % 3 : (ht + 2) % 3;
        if (ht == 2 && hu > 3) hu = 3;
      end
      1: begin
        lim = (ht == 2) ? 4 : 10;
        hu  = up ? (hu + 1) % lim : (hu + lim - 1) % lim;
      end
      2: mt = up ? (mt + 1) % 6  : (mt + 5) % 6;
      3: mu = up ? (mu + 1) % 10 : (mu + 9) % 10;
      4: st = up ? (st + 1) % 6  : (st + 5) % 6;
      5: su = up ? (su + 1) % 10 : (su + 9) % 10;
      default: ;
    endcase
    m_secs = (ht * 10 + hu) * 3600 + (mt * 10 + mu) * 60 + st * 10 + su;
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic applyStimulus(input bit mode, input bit sel, input bit inc, input bit dec,
                               input string name);
    bus.iModeKey = mode;
    bus.iSelKey  = sel;
    bus.iIncKey  = inc;
`ifdef TIME_CORE_DEC_EN
    bus.iDecKey  = dec;
`endif
    if (mode) begin
      if (!m_set) begin
        m_set = 1'b1;
      end else begin
        m_set   = 1'b0;
        m_start = cyc + 1;
      end
      m_sel = 0;
    end else if (m_set) begin
      if (sel)      m_sel = (m_sel + 1) % 6;
      else if (inc) edit(1'b1);
      else if (dec) edit(1'b0);
    end
    push(cyc + 1, 1'b0, 1'b0, name);
    step();
    bus.iModeKey = 1'b0;
    bus.iSelKey  = 1'b0;
    bus.iIncKey  = 1'b0;
`ifdef TIME_CORE_DEC_EN
    bus.iDecKey  = 1'b0;
`endif
  endtask

  task automatic run_ticks(input int n);
    bit day;
    for (int k = 1; k <= n; k++) begin
      m_secs = (m_secs + 1) % 86400;
      day    = (m_secs == 0);
      push(m_start + CLK_HZ * k, 1'b1, day, "sec_tick");
    end
    while (cyc < m_start + CLK_HZ * n) step();
    m_start = m_start + CLK_HZ * n;
  endtask

  task automatic set_time(input logic [23:0] target);
    int guard;
    for (int pos = 0; pos < 6; pos++) begin
      guard = 0;
      while (digit(to_bcd(m_secs), pos) != digit(target, pos) && guard < 12) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "set_inc");
        guard++;
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "set_sel");
    end
  endtask

  // Every expected entry is matched by cycle; any tick with no matching entry is an error.
  bit   hit_tick;
  exp_t cur;
  always @(negedge CLOCK) begin
    hit_tick = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      cur = sb[i];
      if (cur.cyc == cyc) begin
        checkOutput(cur);
        if (cur.sec) hit_tick = 1'b1;
        sb.delete(i);
      end else if (cur.cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s stale: expected at cycle %0d, now %0d", cur.name, cur.cyc, cyc);
        sb.delete(i);
      end
    end
    if (bus.oSecTick && !hit_tick) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_tick @%0d: time=%h sec=1 required sec=0", cyc, bus.oTime);
    end
  end

  task automatic checkOutput(input exp_t e);
    checks++;
    if (bus.oTime !== e.t || bus.oSetMode !== e.mode || int'(bus.oSetSel) != e.sel ||
        bus.oSecTick !== e.sec || bus.oDayTick !== e.day) begin
      errors++;
      $display("[TB] FAIL %s @%0d: got time=%h mode=%b sel=%0d sec=%b day=%b, required time=%h mode=%b sel=%0d sec=%b day=%b",
               e.name, cyc, bus.oTime, bus.oSetMode, bus.oSetSel, bus.oSecTick, bus.oDayTick,
               e.t, e.mode, e.sel, e.sec, e.day);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit s, i, d;
    bus.iModeKey = 1'b0;
    bus.iSelKey  = 1'b0;
    bus.iIncKey  = 1'b0;
`ifdef TIME_CORE_DEC_EN
    bus.iDecKey  = 1'b0;
`endif
    m_secs = from_bcd(INIT_TIME);
    m_set  = 1'b0;
    m_sel  = 0;
    repeat (3) step();
    push(cyc + 1, 1'b0, 1'b0, "reset_state");
    step();
    RESET   = 1'b1;
    m_start = cyc;
    push(m_start + 5, 1'b0, 1'b0, "pre_tick_hold");
    run_ticks(2);

    while (cyc < m_start + CLK_HZ - 1) step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "mode_at_terminal");

    set_time(24'h12_00_00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "sel_to_hu");
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "inc_hu");
    repeat (50) step();
    push(cyc + 1, 1'b0, 1'b0, "set_hold_50");
    step();
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "sel_wrap");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "ht_clamp");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "ht_wrap");

    repeat (40) begin
      s = 1'($urandom_range(0, 1));
      i = 1'($urandom_range(0, 1));
`ifdef TIME_CORE_DEC_EN
      d = 1'($urandom_range(0, 1));
`else
      d = 1'b0;
`endif
      applyStimulus(1'b0, s, i, d, "rand_edit");
      repeat ($urandom_range(0, 2)) step();
    end

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, "mode_inc_exit");
    run_ticks(1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, "run_keys_ignored");
    run_ticks($urandom_range(1, 3));

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "enter_set");
    set_time(24'h01_09_59);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "mode_sel_exit");
    run_ticks(1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "enter_set_again");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "sel_before_reset");
    step();
    RESET  = 1'b0;
    m_secs = from_bcd(INIT_TIME);
    m_set  = 1'b0;
    m_sel  = 0;
    push(cyc, 1'b0, 1'b0, "reset_mid_set");
    repeat (2) step();
    RESET = 1'b1;
    repeat (3) step();

    while (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s never_checked: expected at cycle %0d", cur.name, cur.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
